// File: rtl/control_unit.sv
// rtl/control_unit.sv - decode-stage control unit: opcode to registered EX/M/WB bundles.
// Optional macro CTRL_ADDI_EN adds addi (001000) decode support.
`timescale 1ns/1ps

module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       stall,
    input  logic       flush,
    output logic [3:0] EX,
    output logic [2:0] M,
    output logic [1:0] WB,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    logic [3:0] ex_d, ex_q;
    logic [2:0] m_d, m_q;
    logic [1:0] wb_d, wb_q;
    logic       illegal_d, illegal_q;

    // Unsupported opcodes fall through to an all-zero NOP bundle with the flag set.
    always_comb begin
        ex_d      = 4'b0000;
        m_d       = 3'b000;
        wb_d      = 2'b00;
        illegal_d = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ex_d = 4'b1100; m_d = 3'b000; wb_d = 2'b10; illegal_d = 1'b0;
            end
            OP_LW: begin
                ex_d = 4'b0001; m_d = 3'b010; wb_d = 2'b11; illegal_d = 1'b0;
            end
            OP_SW: begin
                ex_d = 4'b0001; m_d = 3'b001; wb_d = 2'b00; illegal_d = 1'b0;
            end
            OP_BEQ: begin
                ex_d = 4'b0010; m_d = 3'b100; wb_d = 2'b00; illegal_d = 1'b0;
            end
`ifdef CTRL_ADDI_EN
            OP_ADDI: begin
                ex_d = 4'b0001; m_d = 3'b000; wb_d = 2'b10; illegal_d = 1'b0;
            end
`endif
            default: begin
                ex_d = 4'b0000; m_d = 3'b000; wb_d = 2'b00; illegal_d = 1'b1;
            end
        endcase
    end

    // Flush beats stall so a bubble can be forced into a held stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= 4'b0000;
            m_q       <= 3'b000;
            wb_q      <= 2'b00;
            illegal_q <= 1'b0;
        end else if (flush) begin
            ex_q      <= 4'b0000;
            m_q       <= 3'b000;
            wb_q      <= 2'b00;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            ex_q      <= ex_d;
            m_q       <= m_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign EX      = ex_q;
    assign M       = m_q;
    assign WB      = wb_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven self-checking bench for control_unit.
`timescale 1ns/1ps

module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       stall;
    logic       flush;
    logic [3:0] EX;
    logic [2:0] M;
    logic [1:0] WB;
    logic       illegal;

    int n_cmp = 0;
    int n_err = 0;

    control_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .stall   (stall),
        .flush   (flush),
        .EX      (EX),
        .M       (M),
        .WB      (WB),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       st;
        logic       fl;
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       ill;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [3:0] ex, input logic [2:0] m,
                         input logic [1:0] wb, input logic ill);
        n_cmp++;
        if (EX !== ex || M !== m || WB !== wb || illegal !== ill) begin
            n_err++;
            $display("FAIL %s: got EX=%b M=%b WB=%b illegal=%b, expected EX=%b M=%b WB=%b illegal=%b",
                     name, EX, M, WB, illegal, ex, m, wb, ill);
        end
    endtask

    task automatic drive_edge(input logic [5:0] op, input logic st, input logic fl);
        @(negedge clk);
        opcode = op;
        stall  = st;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 1'b0, 1'b0, 4'b1100, 3'b000, 2'b10, 1'b0};
        vecs[1]  = '{6'b100011, 1'b0, 1'b0, 4'b0001, 3'b010, 2'b11, 1'b0};
        vecs[2]  = '{6'b101011, 1'b0, 1'b0, 4'b0001, 3'b001, 2'b00, 1'b0};
        vecs[3]  = '{6'b000100, 1'b0, 1'b0, 4'b0010, 3'b100, 2'b00, 1'b0};
        vecs[4]  = '{6'b100000, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1};
        vecs[5]  = '{6'b100011, 1'b0, 1'b0, 4'b0001, 3'b010, 2'b11, 1'b0};
        vecs[6]  = '{6'b000000, 1'b1, 1'b0, 4'b0001, 3'b010, 2'b11, 1'b0};
        vecs[7]  = '{6'b000000, 1'b1, 1'b0, 4'b0001, 3'b010, 2'b11, 1'b0};
        vecs[8]  = '{6'b000000, 1'b0, 1'b0, 4'b1100, 3'b000, 2'b10, 1'b0};
        vecs[9]  = '{6'b100011, 1'b0, 1'b0, 4'b0001, 3'b010, 2'b11, 1'b0};
        vecs[10] = '{6'b000000, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00, 1'b0};
        vecs[11] = '{6'b100000, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1};
        vecs[12] = '{6'b101011, 1'b1, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1};
        vecs[13] = '{6'b100000, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00, 1'b0};
        vecs[14] = '{6'b111111, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1};

        rst_n  = 1'b0;
        opcode = 6'b000000;
        stall  = 1'b0;
        flush  = 1'b0;

        // Reset held: outputs stay zero while the clock runs with a decodable opcode.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_%0d", i), 4'b0000, 3'b000, 2'b00, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive_edge(vecs[i].op, vecs[i].st, vecs[i].fl);
            check($sformatf("vec_%0d_op%b_st%b_fl%b", i, vecs[i].op, vecs[i].st, vecs[i].fl),
                  vecs[i].ex, vecs[i].m, vecs[i].wb, vecs[i].ill);
        end

        // Opcode wiggling between edges must not reach the outputs.
        drive_edge(6'b000100, 1'b0, 1'b0);
        check("beq_capture", 4'b0010, 3'b100, 2'b00, 1'b0);
        opcode = 6'b100011;
        #2;
        opcode = 6'b000000;
        #1;
        check("midcycle_opcode_change", 4'b0010, 3'b100, 2'b00, 1'b0);

        // Asynchronous reset between edges, then held across edges with stall asserted.
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 4'b0000, 3'b000, 2'b00, 1'b0);
        stall  = 1'b1;
        opcode = 6'b100011;
        @(posedge clk);
        #1;
        check("reset_over_stall", 4'b0000, 3'b000, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_after_reset", 4'b0001, 3'b010, 2'b11, 1'b0);

        drive_edge(6'b001000, 1'b0, 1'b0);
`ifdef CTRL_ADDI_EN
        check("addi_enabled", 4'b0001, 3'b000, 2'b10, 1'b0);
`else
        check("addi_disabled", 4'b0000, 3'b000, 2'b00, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
